// File: rtl/uart_pkg.sv
// Shared types and line levels for the serial transmit path.
// Imported by the frame transmitter so state names and idle/start/stop levels stay consistent.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_sr.sv
// Parallel-to-serial shift register; loads a word and presents one end of it as serial_out.
// Vacated positions fill with ones so an empty register reads as an idle line.
module flex_pts_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load_enable,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);

    logic [NUM_BITS-1:0] r_data;

    // NOTE: a single flopped word is cheap to reset; resetting it to ones keeps serial_out idle-high.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data <= '1;
        end else if (load_enable) begin
            r_data <= parallel_in;
        end else if (shift_enable) begin
            if (SHIFT_MSB) begin
                r_data <= {r_data[NUM_BITS-2:0], 1'b1};
            end else begin
                r_data <= {1'b1, r_data[NUM_BITS-1:1]};
            end
        end
    end

    assign serial_out = SHIFT_MSB ? r_data[NUM_BITS-1] : r_data[0];

endmodule

// File: rtl/uart_tx_frame.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// The pin level is computed one cycle ahead and registered so the line never glitches.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int NUM_DATA_BITS = 8,
    parameter int CLKS_PER_BIT  = 10,
    parameter int PARITY_EN     = 0
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_DATA_BITS-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     serial_out,
    output logic                     tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(NUM_DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BITS - 1);

    tx_state_t        r_state;
    tx_state_t        w_next_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [IDX_W-1:0] r_bit_idx;
    logic             r_serial_out;
    logic             r_tx_done;
    logic             r_parity;
    logic             w_next_serial;
    logic             w_next_done;
    logic             w_accept;
    logic             w_bit_end;
    logic             w_shift;
    logic             w_sr_out;

    assign tx_ready   = (r_state == IDLE);
    assign w_accept   = tx_valid && tx_ready;
    assign w_bit_end  = (r_clk_cnt == CNT_LAST);
    assign serial_out = r_serial_out;
    assign tx_done    = r_tx_done;

    // Shifting happens on entry to each data bit, so the register's LSB is always the next bit to send.
    flex_pts_sr #(
        .NUM_BITS (NUM_DATA_BITS),
        .SHIFT_MSB(1'b0)
    ) u_shift_reg (
        .clk         (clk),
        .n_rst       (n_rst),
        .load_enable (w_accept),
        .shift_enable(w_shift),
        .parallel_in (tx_data),
        .serial_out  (w_sr_out)
    );

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_serial_out <= IDLE_LEVEL;
            r_tx_done    <= 1'b0;
            r_parity     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_serial_out <= w_next_serial;
            r_tx_done    <= w_next_done;
            if (r_state == IDLE || w_bit_end) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
            if (r_state != DATA) begin
                r_bit_idx <= '0;
            end else if (w_bit_end) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_accept) begin
                r_parity <= ^tx_data;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_next_serial = r_serial_out;
        w_next_done   = 1'b0;
        w_shift       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_next_serial = IDLE_LEVEL;
                if (w_accept) begin
                    w_next_state  = START;
                    w_next_serial = START_LEVEL;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_next_state  = DATA;
                    w_next_serial = w_sr_out;
                    w_shift       = 1'b1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx != IDX_LAST) begin
                        w_next_serial = w_sr_out;
                        w_shift       = 1'b1;
                    end else if (PARITY_EN != 0) begin
                        w_next_state  = PARITY;
                        w_next_serial = r_parity;
                    end else begin
                        w_next_state  = STOP;
                        w_next_serial = STOP_LEVEL;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_next_state  = STOP;
                    w_next_serial = STOP_LEVEL;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_next_state  = IDLE;
                    w_next_serial = IDLE_LEVEL;
                    w_next_done   = 1'b1;
                end
            end
            default: begin
                w_next_state  = IDLE;
                w_next_serial = IDLE_LEVEL;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: one default instance and one with parity, checked against
// a frame-level model that lists the expected line level for every bit period.
module tb_uart_tx_frame;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] d_data = '0;
    logic [7:0] p_data = '0;
    logic       d_valid = 1'b0;
    logic       p_valid = 1'b0;
    logic       d_ready, d_serial, d_done;
    logic       p_ready, p_serial, p_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut (
        .clk(clk), .n_rst(n_rst), .tx_data(d_data), .tx_valid(d_valid),
        .tx_ready(d_ready), .serial_out(d_serial), .tx_done(d_done)
    );

    uart_tx_frame #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
        .clk(clk), .n_rst(n_rst), .tx_data(p_data), .tx_valid(p_valid),
        .tx_ready(p_ready), .serial_out(p_serial), .tx_done(p_done)
    );

    function automatic logic obs_serial(input bit sel);
        return sel ? p_serial : d_serial;
    endfunction

    function automatic logic obs_ready(input bit sel);
        return sel ? p_ready : d_ready;
    endfunction

    function automatic logic obs_done(input bit sel);
        return sel ? p_done : d_done;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            p_valid = v;
            p_data  = d;
        end else begin
            d_valid = v;
            d_data  = d;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input bit sel, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s idle_line[%0d]", name, i), obs_serial(sel), 1);
            check($sformatf("%s idle_done[%0d]", name, i), obs_done(sel), 0);
            check($sformatf("%s idle_ready[%0d]", name, i), obs_ready(sel), 1);
        end
    endtask

    // Caller has already driven valid/data for this word during an IDLE cycle (at a negedge).
    task automatic frame(input bit sel, input logic [7:0] data, input bit keep_valid,
                         input logic [7:0] next_data, input int inject_k, input string name);
        logic bits[$];
        int   f;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (sel) bits.push_back(logic'($countones(data) % 2));
        bits.push_back(1'b1);
        f = bits.size() * CPB;
        check({name, " accept_ready"}, obs_ready(sel), 1);
        @(posedge clk);
        for (int k = 1; k <= f; k++) begin
            @(negedge clk);
            check($sformatf("%s line c%0d", name, k), obs_serial(sel), bits[(k - 1) / CPB]);
            check($sformatf("%s done c%0d", name, k), obs_done(sel), 0);
            check($sformatf("%s ready c%0d", name, k), obs_ready(sel), 0);
            if (k == 1) drive(sel, keep_valid, keep_valid ? next_data : 8'($urandom));
            if (inject_k != 0 && k == inject_k) drive(sel, 1'b1, 8'hFF);
            if (inject_k != 0 && k == inject_k + 1) drive(sel, 1'b0, 8'($urandom));
        end
        @(negedge clk);
        check($sformatf("%s done c%0d", name, f + 1), obs_done(sel), 1);
        check($sformatf("%s ready c%0d", name, f + 1), obs_ready(sel), 1);
        check($sformatf("%s line c%0d", name, f + 1), obs_serial(sel), 1);
    endtask

    task automatic send(input bit sel, input logic [7:0] data, input string name);
        int budget;
        budget = 0;
        @(negedge clk);
        while (obs_ready(sel) !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        drive(sel, 1'b1, data);
        frame(sel, data, 1'b0, 8'h00, 0, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset line", d_serial, 1);
        check("reset ready", d_ready, 1);
        check("reset done", d_done, 0);
        check("reset p_line", p_serial, 1);
        check("reset p_ready", p_ready, 1);
        check("reset p_done", p_done, 0);
        n_rst = 1'b1;
        idle_check(0, 50, "post_reset");
        idle_check(1, 5, "post_reset_p");

        send(0, 8'hA5, "a5");
        idle_check(0, 3, "after_a5");

        @(negedge clk);
        drive(0, 1'b1, 8'h00);
        frame(0, 8'h00, 1'b1, 8'hFF, 0, "b2b_00");
        frame(0, 8'hFF, 1'b0, 8'h00, 0, "b2b_ff");
        idle_check(0, 5, "after_b2b");

        send(1, 8'h07, "par_07");
        send(1, 8'h03, "par_03");
        idle_check(1, 3, "after_par");

        @(negedge clk);
        drive(0, 1'b1, 8'h3C);
        frame(0, 8'h3C, 1'b0, 8'h00, 35, "mid_req_3c");
        idle_check(0, 20, "after_mid_req");

        // Abort partway through data bit 3 (cycles 41..50), where 0xF0 drives a 0.
        @(negedge clk);
        drive(0, 1'b1, 8'hF0);
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, 1'b0, 8'h00);
        end
        check("abort pre_reset_line", d_serial, 0);
        #2 n_rst = 1'b0;
        #1;
        check("abort async_line", d_serial, 1);
        check("abort ready", d_ready, 1);
        check("abort done", d_done, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        idle_check(0, 20, "after_abort");
        send(0, 8'h55, "post_abort_55");

        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < 2; s++) begin
                idle_check(s[0], int'($urandom_range(0, 5)), $sformatf("rand_gap%0d_%0d", r, s));
                send(s[0], 8'($urandom), $sformatf("rand%0d_%0d", r, s));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
